// File: rtl/cfg_chain_ctrl_if.sv
// Handshake/bus bundle for cfg_chain_ctrl.
//   slave  : the controller (consumes start/in_*/config_out, drives the rest)
//   master : the SW-fed word source, readback sink and DUT chain side
// Signals: start, in_valid/in_ready/in_data (load stream),
//          rd_valid/rd_data (readback stream), busy, done, underrun,
//          config_clk/config_in/config_load (to DUT chain), config_out (from chain).
interface cfg_chain_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              config_clk;
  logic              config_in;
  logic              config_load;
  logic              config_out;

  modport slave (
    input  start, in_valid, in_data, config_out,
    output in_ready, rd_valid, rd_data, busy, done, underrun,
           config_clk, config_in, config_load
  );

  modport master (
    output start, in_valid, in_data, config_out,
    input  in_ready, rd_valid, rd_data, busy, done, underrun,
           config_clk, config_in, config_load
  );
endinterface

// File: rtl/cfg_chain_ctrl.sv
// Configuration shift-chain sequencer.
// Pulls WORD_W-bit words from the load stream, shifts them MSB first into the
// DUT chain on a divided config_clk, assembles config_out readback into words,
// then pulses config_load for CLK_DIV cycles and reports done.
// Ports:
//   S_AXI_ACLK     sole clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   abort          (only with CFG_CHAIN_ABORT_EN) drop back to IDLE at once
//   bus            cfg_chain_ctrl_if.slave: start, in_*, rd_*, busy, done,
//                  underrun, config_clk/in/load, config_out
// Build option: define CFG_CHAIN_ABORT_EN to add the abort input.
// Constraints: CHAIN_LEN a multiple of WORD_W, WORD_W >= 2, CLK_DIV >= 1.
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
`ifdef CFG_CHAIN_ABORT_EN
  input  logic abort,
`endif
  cfg_chain_ctrl_if.slave bus
);

  localparam int BCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int WBW = $clog2(WORD_W);
  localparam int PCW = $clog2(CLK_DIV + 1);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);
  localparam logic [WBW-1:0] LAST_WBIT = WBW'(WORD_W - 1);
  localparam logic [PCW-1:0] PH_LOAD   = PCW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE
  } state_t;

  state_t            r_state, w_next;
  logic [BCW-1:0]    r_bit_cnt;
  logic [WBW-1:0]    r_wbit;
  logic [PCW-1:0]    r_ph;
  logic [WORD_W-1:0] r_shreg, r_rd_shift, r_rd_data;
  logic              r_rd_valid, r_underrun;

  logic w_abort, w_ph_end, w_ph_first, w_hs, w_sample, w_bit_end;
  logic w_in_ready, w_cfg_clk, w_cfg_load, w_busy, w_done;

`ifdef CFG_CHAIN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // phase counter counts down from CLK_DIV-1; its reload value marks the first cycle
  assign w_ph_end   = (r_ph == '0);
  assign w_ph_first = (r_ph == PH_LOAD);
  assign w_hs       = (r_state == FETCH) && bus.in_valid;
  assign w_sample   = (r_state == SHIFT_HI) && w_ph_first && !w_abort;
  assign w_bit_end  = (r_state == SHIFT_HI) && w_ph_end && !w_abort;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_cfg_clk  = 1'b0;
    w_cfg_load = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = FETCH;
      end
      FETCH: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = SHIFT_LO;
      end
      SHIFT_LO: if (w_ph_end) w_next = SHIFT_HI;
      SHIFT_HI: begin
        w_cfg_clk = 1'b1;
        if (w_ph_end) begin
          if (r_bit_cnt == LAST_BIT)   w_next = LOAD;
          else if (r_wbit == LAST_WBIT) w_next = FETCH;
          else                          w_next = SHIFT_LO;
        end
      end
      LOAD: begin
        w_cfg_load = 1'b1;
        if (w_ph_end) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bit_cnt  <= '0;
      r_wbit     <= '0;
      r_ph       <= '0;
      r_shreg    <= '0;
      r_rd_shift <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state != w_next)  r_ph <= PH_LOAD;
      else if (!w_ph_end)     r_ph <= r_ph - 1'b1;

      if ((r_state == IDLE) && bus.start) begin
        r_bit_cnt  <= '0;
        r_wbit     <= '0;
        r_underrun <= 1'b0;
        r_rd_shift <= '0;  // drops any partial word left by an abort
      end
      if ((r_state == FETCH) && !bus.in_valid) r_underrun <= 1'b1;
      if (w_hs) r_shreg <= bus.in_data;

      if (w_sample) begin
        r_rd_shift <= {r_rd_shift[WORD_W-2:0], bus.config_out};
        if (r_wbit == LAST_WBIT) begin
          r_rd_data  <= {r_rd_shift[WORD_W-2:0], bus.config_out};
          r_rd_valid <= 1'b1;
        end
      end

      // bit_cnt stops at the last bit; the word-end path refetches instead of shifting
      if (w_bit_end && (r_bit_cnt != LAST_BIT)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_wbit == LAST_WBIT) r_wbit <= '0;
        else begin
          r_wbit  <= r_wbit + 1'b1;
          r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.config_clk  = w_cfg_clk;
  assign bus.config_load = w_cfg_load;
  // MSB of the shift register holds its value through FETCH stalls and LOAD
  assign bus.config_in   = r_shreg[WORD_W-1];
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_data;
  assign bus.underrun    = r_underrun;

endmodule
